// File: rtl/adder_nbit_seq.sv
// Multi-cycle unsigned adder: a + b + carry_in, one CHUNK-bit slice per cycle.
// Valid/ready handshakes on both sides; the carry is held in a register between slices.
module adder_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("adder_nbit_seq: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;

    int               w_base;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_slice;

    // Slice adder is CHUNK+1 bits; its top bit is the carry into the next slice
    always_comb begin
        w_base  = int'(r_idx) * CHUNK;
        w_a_sl  = r_a[w_base +: CHUNK];
        w_b_sl  = r_b[w_base +: CHUNK];
        w_slice = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum[w_base +: CHUNK] <= w_slice[CHUNK-1:0];
                    r_carry                <= w_slice[CHUNK];
                    if (r_idx == LAST) begin
                        r_ovf   <= w_slice[CHUNK];
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Bench for adder_nbit_seq: three configurations (16/4, 32/8, 16/16) driven in lockstep
// and checked against plain WIDTH+1-bit addition.
module tb_adder_nbit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        cin = 1'b0;
    logic [15:0] a16;
    logic [15:0] b16;

    logic        rdy_a, rdy_b, rdy_c;
    logic        vld_a, vld_b, vld_c;
    logic [15:0] sum_a, sum_c;
    logic [31:0] sum_b;
    logic        ovf_a, ovf_b, ovf_c;

    int n_vec = 0;
    int n_err = 0;

    assign a16 = op_a[15:0];
    assign b16 = op_b[15:0];

    always #5 clk = ~clk;

    adder_nbit_seq #(.WIDTH(16), .CHUNK(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .a(a16), .b(b16), .carry_in(cin), .out_valid(vld_a),
        .out_ready(out_ready), .sum(sum_a), .overflow(ovf_a)
    );

    adder_nbit_seq #(.WIDTH(32), .CHUNK(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .a(op_a), .b(op_b), .carry_in(cin), .out_valid(vld_b),
        .out_ready(out_ready), .sum(sum_b), .overflow(ovf_b)
    );

    adder_nbit_seq #(.WIDTH(16), .CHUNK(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .a(a16), .b(b16), .carry_in(cin), .out_valid(vld_c),
        .out_ready(out_ready), .sum(sum_c), .overflow(ovf_c)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [15:0] s16;
        logic        o16;
        logic [31:0] s32;
        logic        o32;
        bit          bp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: full-precision addition truncated to w bits, carry at bit w
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c, input int w);
        logic [63:0] m;
        logic [63:0] f;
        m = (64'd1 << w) - 64'd1;
        f = ({32'd0, x} & m) + ({32'd0, y} & m) + {63'd0, c};
        return f[32:0];
    endfunction

    task automatic chk_results(input string tag, input logic [15:0] e16, input logic o16,
                               input logic [31:0] e32, input logic o32);
        chk({tag, " sum16x4"}, {48'd0, sum_a}, {48'd0, e16});
        chk({tag, " ovf16x4"}, {63'd0, ovf_a}, {63'd0, o16});
        chk({tag, " sum32x8"}, {32'd0, sum_b}, {32'd0, e32});
        chk({tag, " ovf32x8"}, {63'd0, ovf_b}, {63'd0, o32});
        chk({tag, " sum16x16"}, {48'd0, sum_c}, {48'd0, e16});
        chk({tag, " ovf16x16"}, {63'd0, ovf_c}, {63'd0, o16});
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [15:0] e16, input logic o16,
                          input logic [31:0] e32, input logic o32, input bit bp);
        int la;
        int lb;
        int lc;
        la = 0;
        lb = 0;
        lc = 0;
        @(negedge clk);
        chk({tag, " in_ready"}, {61'd0, rdy_a, rdy_b, rdy_c}, 64'd7);
        op_a = av;
        op_b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        cin = 1'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vld_a && la == 0) la = c;
            if (vld_b && lb == 0) lb = c;
            if (vld_c && lc == 0) lc = c;
            if (la != 0 && lb != 0 && lc != 0) break;
        end
        chk({tag, " lat16x4"}, 64'(la), 64'd4);
        chk({tag, " lat32x8"}, 64'(lb), 64'd4);
        chk({tag, " lat16x16"}, 64'(lc), 64'd1);
        chk_results(tag, e16, o16, e32, o32);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                op_a = $urandom;
                op_b = $urandom;
                cin = 1'($urandom);
                @(negedge clk);
                chk({tag, " bp out_valid"}, {61'd0, vld_a, vld_b, vld_c}, 64'd7);
                chk({tag, " bp in_ready"}, {61'd0, rdy_a, rdy_b, rdy_c}, 64'd0);
                chk_results({tag, " bp"}, e16, o16, e32, o32);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " rel out_valid"}, {61'd0, vld_a, vld_b, vld_c}, 64'd0);
        chk({tag, " rel in_ready"}, {61'd0, rdy_a, rdy_b, rdy_c}, 64'd7);
        chk_results({tag, " rel"}, e16, o16, e32, o32);
        if (bp) begin
            @(negedge clk);
            chk({tag, " not taken"}, {61'd0, vld_a, vld_b, vld_c}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] r16;
        logic [32:0] r32;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        tbl[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 16'hFFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 16'hFFFE, 1'b1, 32'h0001_FFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 16'h0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0000, 32'h0000_FFFF, 1'b0, 16'hFFFF, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'h0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", {61'd0, rdy_a, rdy_b, rdy_c}, 64'd7);
        chk("reset out_valid", {61'd0, vld_a, vld_b, vld_c}, 64'd0);
        chk_results("reset", 16'h0000, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c,
                   tbl[i].s16, tbl[i].o16, tbl[i].s32, tbl[i].o32, tbl[i].bp);
        end

        // Reset after two ADD cycles discards the partial result
        @(negedge clk);
        op_a = 32'h5A5A_F0F0;
        op_b = 32'hA5A5_0F0F;
        cin = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", {61'd0, vld_a, vld_b, vld_c}, 64'd0);
        chk("midrst in_ready", {61'd0, rdy_a, rdy_b, rdy_c}, 64'd7);
        chk_results("midrst", 16'h0000, 1'b0, 32'h0, 1'b0);
        run_op("after_rst", 32'h0000_1234, 32'h0000_4321, 1'b0,
               16'h5555, 1'b0, 32'h0000_5555, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            r16 = ref_add(ra, rb, rc, 16);
            r32 = ref_add(ra, rb, rc, 32);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, r16[15:0], r16[16],
                   r32[31:0], r32[32], (i % 8 == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
